// File: rtl/scram_pkg.sv
// rtl/scram_pkg.sv - shared constants and word-level datapath function for the self-synchronous scrambler
package scram_pkg;

    localparam int SCRAM_MAX_W     = 64;
    localparam int SCRAM_MAX_LEN   = 64;
    localparam int MODE_SCRAMBLE   = 0;
    localparam int MODE_DESCRAMBLE = 1;

    typedef struct packed {
        logic [SCRAM_MAX_W-1:0]   word;
        logic [SCRAM_MAX_LEN-1:0] hist;
    } scram_res_t;

    // hist[k-1] holds the line bit k positions back; bits above w/len are don't-care.
    function automatic scram_res_t scram_word(
        input logic [SCRAM_MAX_W-1:0]   data,
        input logic [SCRAM_MAX_LEN-1:0] hist,
        input logic [SCRAM_MAX_LEN-1:0] taps,
        input int                       mode,
        input int                       w
    );
        scram_res_t               res;
        logic [SCRAM_MAX_LEN-1:0] h;
        logic                     s;
        logic                     line;
        res  = '0;
        h    = hist;
        s    = 1'b0;
        line = 1'b0;
        for (int i = SCRAM_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                s           = data[i] ^ (^(h & taps));
                line        = (mode == MODE_DESCRAMBLE) ? data[i] : s;
                res.word[i] = s;
                h           = {h[SCRAM_MAX_LEN-2:0], line};
            end
        end
        res.hist = h;
        return res;
    endfunction

endpackage

// File: rtl/scram_core.sv
// rtl/scram_core.sv - history register, lock counter and unrolled bit datapath
module scram_core
    import scram_pkg::*;
#(
    parameter int             W    = 4,
    parameter int             LEN  = 3,
    parameter logic [LEN-1:0] TAPS = 3'b110,
    parameter int             MODE = MODE_SCRAMBLE,
    parameter logic [LEN-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] word_o,
    output logic         locked_o
);

    localparam int CNT_W = $clog2(LEN + 1);

    logic [LEN-1:0]   hist_q, hist_d, hist_cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    scram_res_t       res;
    logic             unused_res;

    // A flush in the same cycle as an accept makes that word start from SEED.
    assign hist_cur = flush_i ? SEED : hist_q;
    assign cnt_cur  = flush_i ? '0 : cnt_q;

    assign res = scram_word(SCRAM_MAX_W'(data_i), SCRAM_MAX_LEN'(hist_cur),
                            SCRAM_MAX_LEN'(TAPS), MODE, W);

    assign word_o     = res.word[W-1:0];
    assign unused_res = ^res;
    assign locked_o   = (MODE == MODE_SCRAMBLE) ? 1'b1 : (int'(cnt_cur) >= LEN);

    always_comb begin
        hist_d = hist_cur;
        cnt_d  = cnt_cur;
        if (en_i) begin
            hist_d = res.hist[LEN-1:0];
            if (int'(cnt_cur) + W >= LEN) begin
                cnt_d = CNT_W'(LEN);
            end else begin
                cnt_d = cnt_cur + CNT_W'(W);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= SEED;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ss_scrambler.sv
// rtl/ss_scrambler.sv - valid/ready wrapper with output register and bypass around scram_core
module ss_scrambler
    import scram_pkg::*;
#(
    parameter int             W    = 4,
    parameter int             LEN  = 3,
    parameter logic [LEN-1:0] TAPS = 3'b110,
    parameter int             MODE = MODE_SCRAMBLE,
    parameter logic [LEN-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_locked
);

    logic         accept;
    logic [W-1:0] core_word;
    logic         core_locked;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_locked_q, out_locked_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    scram_core #(
        .W    (W),
        .LEN  (LEN),
        .TAPS (TAPS),
        .MODE (MODE),
        .SEED (SEED)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .en_i     (accept && !in_bypass),
        .data_i   (in_data),
        .word_o   (core_word),
        .locked_o (core_locked)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_locked_d = out_locked_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_bypass ? in_data : core_word;
            out_locked_d = in_bypass || core_locked;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_locked_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_locked_q <= out_locked_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_locked = out_locked_q;

endmodule
